// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: frames cs_n with setup/hold/gap delays and moves bytes
// between host-side TX/RX FIFOs and a single-byte-in-flight spi_master handshake.
module spi_xfer_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int DELAY_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DELAY_WIDTH-1:0] cs_setup,
    input  logic [DELAY_WIDTH-1:0] cs_hold,
    input  logic [DELAY_WIDTH-1:0] cs_gap,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [7:0]             tx_data,
    input  logic                   tx_vld,
    output logic                   tx_rdy,
    output logic [7:0]             rx_data,
    output logic                   rx_vld,
    input  logic                   rx_rdy,
    output logic                   busy,
    output logic                   done,
    output logic                   cs_n,
    output logic [7:0]             spi_din,
    output logic                   spi_din_vld,
    input  logic                   spi_din_rdy,
    input  logic [7:0]             spi_dout,
    input  logic                   spi_dout_vld
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP, S_DONE} state_t;

    state_t                 state_q;
    logic [DELAY_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0]   len_q, issued_q, received_q, received_inc;
    logic                   inflight_q, cs_n_q, done_q;

    logic [7:0]    tx_mem_q [FIFO_DEPTH];
    logic [7:0]    rx_mem_q [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    // Issue only when the RX FIFO can already absorb the returning byte.
    assign spi_din_vld = (state_q == S_XFER) && !inflight_q && (tx_cnt_q != '0)
                         && (issued_q < len_q) && (rx_cnt_q < DEPTH_C);
    assign spi_din     = tx_mem_q[tx_rd_q];
    assign tx_pop      = spi_din_vld && spi_din_rdy;
    assign tx_push     = tx_vld && ((tx_cnt_q != DEPTH_C) || tx_pop);
    assign rx_push     = spi_dout_vld && inflight_q;
    assign rx_pop      = rx_rdy && rx_vld;

    assign tx_rdy       = (tx_cnt_q != DEPTH_C);
    assign rx_vld       = (rx_cnt_q != '0);
    assign rx_data      = rx_mem_q[rx_rd_q];
    assign cmd_rdy      = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign cs_n         = cs_n_q;
    assign done         = done_q;
    assign received_inc = received_q + 1'b1;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)
            tx_cnt_d = tx_cnt_q + 1'b1;
        else if (!tx_push && tx_pop)
            tx_cnt_d = tx_cnt_q - 1'b1;
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop)
            rx_cnt_d = rx_cnt_q + 1'b1;
        else if (!rx_push && rx_pop)
            rx_cnt_d = rx_cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= tx_data;
        if (rx_push) rx_mem_q[rx_wr_q] <= spi_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            inflight_q <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_q + 1'b1;
            if (tx_pop) begin
                issued_q   <= issued_q + 1'b1;
                inflight_q <= 1'b1;
            end
            if (rx_push) begin
                received_q <= received_inc;
                inflight_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (cmd_vld) begin
                        len_q      <= cmd_len;
                        issued_q   <= '0;
                        received_q <= '0;
                        if (cmd_len != '0) begin
                            state_q <= S_SETUP;
                            cs_n_q  <= 1'b0;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_q == cs_setup) begin
                        state_q <= S_XFER;
                        cnt_q   <= '0;
                    end
                end
                S_XFER: begin
                    cnt_q <= '0;
                    if (rx_push && (received_inc == len_q))
                        state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (cnt_q == cs_hold) begin
                        state_q <= S_GAP;
                        cs_n_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_GAP: begin
                    if (cnt_q == cs_gap) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: loopback spi_master model, RX scoreboard, timing table
// and hand-written sequences for underflow, RX back-pressure, null command and reset.
module tb_spi_xfer_ctrl;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cs_setup, cs_hold, cs_gap, cmd_len;
    logic       cmd_vld, cmd_rdy;
    logic [7:0] tx_data;
    logic       tx_vld, tx_rdy;
    logic [7:0] rx_data;
    logic       rx_vld, rx_rdy;
    logic       busy, done, cs_n;
    logic [7:0] spi_din;
    logic       spi_din_vld, spi_din_rdy;
    logic [7:0] spi_dout;
    logic       spi_dout_vld;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(8), .DELAY_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .cs_setup(cs_setup), .cs_hold(cs_hold), .cs_gap(cs_gap),
        .cmd_len(cmd_len), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
        .busy(busy), .done(done), .cs_n(cs_n),
        .spi_din(spi_din), .spi_din_vld(spi_din_vld), .spi_din_rdy(spi_din_rdy),
        .spi_dout(spi_dout), .spi_dout_vld(spi_dout_vld)
    );

    typedef struct {
        int len; int setup; int hold; int gap;
        int exp_din; int exp_rise; int exp_done;
    } vec_t;
    vec_t tbl [4];

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    int ncyc = 0;
    int t_fall, t_din, t_lastrx, t_rise, t_done;
    int n_hs, n_rx, n_done, n_fall;
    logic prev_cs = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait expired", name);
    endtask

    task automatic clear_meas();
        t_fall = -1; t_din = -1; t_lastrx = -1; t_rise = -1; t_done = -1;
        n_hs = 0; n_rx = 0; n_done = 0; n_fall = 0;
    endtask

    // Loopback spi_master: accepts a byte, returns the same byte 4 cycles later.
    logic       m_busy = 1'b0, m_pend = 1'b0;
    int         m_timer = 0;
    logic [7:0] m_byte = 8'h00;
    initial begin
        spi_din_rdy = 1'b1; spi_dout_vld = 1'b0; spi_dout = 8'h00;
        forever begin
            @(negedge clk);
            spi_dout_vld = 1'b0;
            if (rst) begin
                m_busy = 1'b0; m_pend = 1'b0; spi_din_rdy = 1'b1;
            end else begin
                if (m_pend) begin
                    m_busy = 1'b1; m_timer = 3; spi_din_rdy = 1'b0; m_pend = 1'b0;
                end else if (m_busy) begin
                    m_timer--;
                    if (m_timer == 0) begin
                        spi_dout = m_byte; spi_dout_vld = 1'b1;
                        m_busy = 1'b0; spi_din_rdy = 1'b1;
                    end
                end
                if (spi_din_vld && spi_din_rdy) begin
                    m_pend = 1'b1; m_byte = spi_din;
                end
            end
        end
    end

    // Event monitor and RX scoreboard; samples mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            ncyc++;
            if (rst) begin
                prev_cs = 1'b1;
            end else begin
                if (prev_cs && !cs_n) begin n_fall++; t_fall = ncyc; end
                if (!prev_cs && cs_n) t_rise = ncyc;
                prev_cs = cs_n;
                if (spi_din_vld && spi_din_rdy) begin
                    n_hs++;
                    if (t_din < 0) t_din = ncyc;
                end
                if (spi_dout_vld) begin n_rx++; t_lastrx = ncyc; end
                if (done) begin n_done++; t_done = ncyc; end
                if (rx_vld && rx_rdy) begin
                    if (sb.size() == 0) begin
                        timeout_fail("rx_unexpected_byte");
                    end else begin
                        chk("rx_data", int'(rx_data), int'(sb.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [7:0] b);
        int n = 0;
        while (!tx_rdy && n < 300) begin @(negedge clk); n++; end
        if (!tx_rdy) begin
            timeout_fail("tx_push_wait");
            return;
        end
        tx_data = b; tx_vld = 1'b1; sb.push_back(b);
        @(negedge clk);
        tx_vld = 1'b0;
    endtask

    task automatic start_cmd(input int len, input int s, input int h, input int g, output int tacc);
        cs_setup = 8'(s); cs_hold = 8'(h); cs_gap = 8'(g);
        cmd_len = 8'(len); cmd_vld = 1'b1;
        tacc = ncyc + 1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (n_done == 0 && n < maxc) begin @(negedge clk); n++; end
        if (n_done == 0) timeout_fail("done_wait");
    endtask

    task automatic wait_count(input string name, input int target, input bit use_rx, input int maxc);
        int n = 0;
        while (((use_rx ? n_rx : n_hs) < target) && n < maxc) begin @(negedge clk); n++; end
        if ((use_rx ? n_rx : n_hs) < target) timeout_fail(name);
    endtask

    task automatic run_vec(input vec_t v, input int idx, input bit fixed);
        int tacc;
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;
        clear_meas();
        for (int i = 0; i < v.len; i++)
            push_tx(fixed ? bytes[i] : 8'($urandom_range(0, 255)));
        start_cmd(v.len, v.setup, v.hold, v.gap, tacc);
        wait_done(2000);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_cmd_to_csfall", idx), t_fall - tacc, 1);
        chk($sformatf("v%0d_setup", idx), t_din - t_fall, v.exp_din);
        chk($sformatf("v%0d_hold", idx), t_rise - t_lastrx, v.exp_rise);
        chk($sformatf("v%0d_gap", idx), t_done - t_rise, v.exp_done);
        chk($sformatf("v%0d_bytes", idx), n_hs, v.len);
        chk($sformatf("v%0d_done_pulses", idx), n_done, 1);
        chk($sformatf("v%0d_rx_drained", idx), sb.size(), 0);
    endtask

    initial begin
        int tacc;
        int badcyc;
        rst = 1'b1; cmd_vld = 1'b0; tx_vld = 1'b0; rx_rdy = 1'b1;
        cmd_len = 8'd0; tx_data = 8'd0; cs_setup = 8'd0; cs_hold = 8'd0; cs_gap = 8'd0;
        tbl[0] = '{3, 2, 1, 1, 3, 3, 2};
        tbl[1] = '{1, 0, 0, 0, 1, 2, 1};
        tbl[2] = '{4, 5, 3, 2, 6, 5, 3};
        tbl[3] = '{2, 1, 7, 4, 2, 9, 5};
        clear_meas();
        repeat (3) @(negedge clk);

        chk("rst_cs_n", cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_tx_rdy", tx_rdy, 1);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_vec(tbl[i], i, (i == 0));

        // Null command
        clear_meas();
        cmd_len = 8'd0; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("null_done", done, 1);
        chk("null_cs_n", cs_n, 1);
        @(negedge clk);
        chk("null_cmd_rdy", cmd_rdy, 1);
        chk("null_done_clear", done, 0);
        repeat (3) @(negedge clk);
        chk("null_no_cs_fall", n_fall, 0);

        // TX underflow: second byte arrives long after the first
        clear_meas();
        push_tx(8'h81);
        start_cmd(2, 0, 0, 0, tacc);
        wait_count("underflow_first_rx", 1, 1'b1, 200);
        repeat (2) @(negedge clk);
        badcyc = 0;
        repeat (50) begin
            @(negedge clk);
            if (cs_n || spi_din_vld) badcyc++;
        end
        chk("underflow_stall", badcyc, 0);
        chk("underflow_one_sent", n_hs, 1);
        push_tx(8'h7E);
        wait_done(500);
        repeat (3) @(negedge clk);
        chk("underflow_both_sent", n_hs, 2);
        chk("underflow_done", n_done, 1);

        // RX back-pressure stalls issue at FIFO depth
        clear_meas();
        rx_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push_tx(8'(8'h10 + i));
        start_cmd(6, 1, 1, 1, tacc);
        push_tx(8'h55);
        push_tx(8'hAA);
        repeat (60) @(negedge clk);
        chk("bp_issued", n_hs, DEPTH);
        chk("bp_rx_vld", rx_vld, 1);
        chk("bp_busy", busy, 1);
        chk("bp_din_vld", spi_din_vld, 0);
        rx_rdy = 1'b1;
        wait_done(1000);
        repeat (3) @(negedge clk);
        chk("bp_total_sent", n_hs, 6);
        chk("bp_total_rx", n_rx, 6);
        chk("bp_rx_drained", sb.size(), 0);

        // Reset mid-byte with TX FIFO full
        clear_meas();
        for (int i = 0; i < 4; i++) push_tx(8'(8'hC0 + i));
        start_cmd(6, 0, 0, 0, tacc);
        wait_count("rst_first_issue", 1, 1'b0, 200);
        push_tx(8'hEE);
        chk("pre_rst_tx_full", tx_rdy, 0);
        chk("pre_rst_cs_low", cs_n, 0);
        rst = 1'b1;
        #1;
        chk("midrst_cs_n", cs_n, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_tx_rdy", tx_rdy, 1);
        chk("midrst_rx_vld", rx_vld, 0);
        chk("midrst_cmd_rdy", cmd_rdy, 1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(tbl[1], 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
